// File: rtl/pipemem_io_gen_if.sv
// EX/MEM-to-MEM bus for pipemem_io_gen: store/load requests, address, store data, load result and stall.
interface pipemem_io_gen_if #(
  parameter int DATA_W = 32
);
  logic              mwmem;
  logic              mrmem;
  logic [DATA_W-1:0] malu;
  logic [DATA_W-1:0] mb;
  logic [DATA_W-1:0] mmo;
  logic              mstall;

  modport master (
    output mwmem, mrmem, malu, mb,
    input  mmo, mstall
  );

  modport slave (
    input  mwmem, mrmem, malu, mb,
    output mmo, mstall
  );
endinterface

// File: rtl/pipemem_io_gen.sv
// MEM stage: single-clock data RAM, synchronised input ports, output registers and a stalling 1-cycle load path.
// Optional macro PIPEMEM_OUT_READBACK_EN maps the output registers as readable just above the input ports.
module pipemem_io_gen #(
  parameter int DATA_W      = 32,
  parameter int DMEM_AW     = 5,
  parameter int N_IN        = 2,
  parameter int N_OUT       = 5,
  parameter int IO_SEL_BIT  = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  pipemem_io_gen_if.slave         bus,
  input  logic [N_IN*DATA_W-1:0]  in_port,
  output logic [N_OUT*DATA_W-1:0] out_port
);

  localparam int DEPTH = 2 ** DMEM_AW;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic               io_p0;
  logic [DMEM_AW-1:0] ram_idx_p0;
  logic [3:0]         port_idx_p0;
  logic               st_vld_p0;
  logic               ld_vld_p0;
  logic               stall_p0;
  logic [DATA_W-1:0]  io_rdata_p0;
  logic [DATA_W-1:0]  ram_rdata_p0;
  logic [DATA_W-1:0]  mmo_p1;

  logic [DATA_W-1:0]  in_sync [SYNC_STAGES][N_IN];
  logic [DATA_W-1:0]  out_q   [N_OUT];
  logic [DATA_W-1:0]  ram     [DEPTH];

  // Address bits outside the decode fields are don't-care.
  logic malu_unused;
  assign malu_unused = ^bus.malu;

  // ---- stage p0: address decode ----
  assign io_p0       = bus.malu[IO_SEL_BIT];
  assign ram_idx_p0  = bus.malu[DMEM_AW+1:2];
  assign port_idx_p0 = bus.malu[5:2];

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.mrmem && !bus.mwmem) state_nxt = WAIT;
      WAIT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Requests seen in WAIT are the held repeat of the instruction just serviced.
  always_comb begin
    st_vld_p0 = 1'b0;
    ld_vld_p0 = 1'b0;
    stall_p0  = 1'b0;
    case (state)
      IDLE: begin
        st_vld_p0 = bus.mwmem;
        ld_vld_p0 = bus.mrmem && !bus.mwmem;
        stall_p0  = bus.mrmem && !bus.mwmem;
      end
      default: begin
        st_vld_p0 = 1'b0;
        ld_vld_p0 = 1'b0;
        stall_p0  = 1'b0;
      end
    endcase
  end

  assign bus.mstall = stall_p0;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        for (int k = 0; k < N_IN; k++) begin
          in_sync[s][k] <= '0;
        end
      end
    end else begin
      for (int k = 0; k < N_IN; k++) begin
        in_sync[0][k] <= in_port[k*DATA_W +: DATA_W];
        for (int s = 1; s < SYNC_STAGES; s++) begin
          in_sync[s][k] <= in_sync[s-1][k];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (st_vld_p0 && !io_p0) begin
      ram[ram_idx_p0] <= bus.mb;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < N_OUT; k++) begin
        out_q[k] <= '0;
      end
    end else if (st_vld_p0 && io_p0) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (port_idx_p0 == 4'(k)) begin
          out_q[k] <= bus.mb;
        end
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < N_OUT; g++) begin : g_out
      assign out_port[g*DATA_W +: DATA_W] = out_q[g];
    end
  endgenerate

  // Unmapped io addresses fall through to zero.
  always_comb begin
    io_rdata_p0 = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (port_idx_p0 == 4'(k)) begin
        io_rdata_p0 = in_sync[SYNC_STAGES-1][k];
      end
    end
`ifdef PIPEMEM_OUT_READBACK_EN
    for (int k = 0; k < N_OUT; k++) begin
      if ({1'b0, port_idx_p0} == 5'(N_IN + k)) begin
        io_rdata_p0 = out_q[k];
      end
    end
`endif
  end

  assign ram_rdata_p0 = ram[ram_idx_p0];

  // ---- stage p1: registered load result ----
  always_ff @(posedge clock) begin
    if (reset) begin
      mmo_p1 <= '0;
    end else if (ld_vld_p0) begin
      mmo_p1 <= io_p0 ? io_rdata_p0 : ram_rdata_p0;
    end
  end

  assign bus.mmo = mmo_p1;

endmodule

// File: tb/tb_pipemem_io_gen.sv
// Randomised and directed bench for pipemem_io_gen against a cycle-level behavioural model of the MEM stage.
module tb_pipemem_io_gen;
  localparam int DATA_W      = 32;
  localparam int DMEM_AW     = 5;
  localparam int N_IN        = 2;
  localparam int N_OUT       = 5;
  localparam int IO_SEL_BIT  = 7;
  localparam int SYNC_STAGES = 2;
  localparam int DEPTH       = 1 << DMEM_AW;

  logic                    clock = 1'b0;
  logic                    reset;
  logic [N_IN*DATA_W-1:0]  in_port;
  logic [N_OUT*DATA_W-1:0] out_port;

  pipemem_io_gen_if #(.DATA_W(DATA_W)) bus();

  pipemem_io_gen #(
    .DATA_W(DATA_W), .DMEM_AW(DMEM_AW), .N_IN(N_IN), .N_OUT(N_OUT),
    .IO_SEL_BIT(IO_SEL_BIT), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus), .in_port(in_port), .out_port(out_port)
  );

  always #5 clock = ~clock;

  logic [DATA_W-1:0]      ram_m [DEPTH];
  logic [DATA_W-1:0]      out_m [N_OUT];
  logic [DATA_W-1:0]      mmo_m;
  bit                     wait_m;
  logic [N_IN*DATA_W-1:0] hist [64];
  int                     edge_n;
  int                     checks;
  int                     errors;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s got=%h want=%h (edge %0d)", tag, obs, expv, edge_n);
    end
  endtask

  // One clock cycle: drive at negedge, check stall, advance the model at posedge, check registers at negedge.
  task automatic cyc(input logic w, input logic r, input logic [DATA_W-1:0] a,
                     input logic [DATA_W-1:0] d, input logic rs);
    bit go_st, go_ld, io, exp_stall;
    int idx, p;
    logic [N_IN*DATA_W-1:0] seen;
    logic [DATA_W-1:0] val;
    bus.mwmem = w;
    bus.mrmem = r;
    bus.malu  = a;
    bus.mb    = d;
    reset     = rs;
    #1;
    exp_stall = !wait_m && r && !w;
    chk("mstall", DATA_W'(bus.mstall), DATA_W'(exp_stall));
    @(posedge clock);
    edge_n++;
    hist[edge_n & 63] = in_port;
    if (rs) begin
      wait_m = 1'b0;
      mmo_m  = '0;
      for (int k = 0; k < N_OUT; k++) out_m[k] = '0;
      for (int k = 0; k < SYNC_STAGES; k++) hist[(edge_n - k) & 63] = '0;
    end else begin
      go_st = !wait_m && w;
      go_ld = !wait_m && r && !w;
      io    = a[IO_SEL_BIT];
      idx   = int'(a[DMEM_AW+1:2]);
      p     = int'(a[5:2]);
      if (go_st) begin
        if (io) begin
          if (p < N_OUT) out_m[p] = d;
        end else begin
          ram_m[idx] = d;
        end
      end
      if (go_ld) begin
        val = '0;
        if (!io) begin
          val = ram_m[idx];
        end else if (p < N_IN) begin
          seen = hist[(edge_n - SYNC_STAGES) & 63];
          val  = seen[p*DATA_W +: DATA_W];
        end
`ifdef PIPEMEM_OUT_READBACK_EN
        else if (p < N_IN + N_OUT) begin
          val = out_m[p - N_IN];
        end
`endif
        mmo_m = val;
      end
      wait_m = go_ld;
    end
    @(negedge clock);
    chk("mmo", bus.mmo, mmo_m);
    for (int k = 0; k < N_OUT; k++) chk($sformatf("out_port%0d", k), out_port[k*DATA_W +: DATA_W], out_m[k]);
  endtask

  // A load plus the held repeat of the same request during its WAIT cycle.
  task automatic load2(input logic [DATA_W-1:0] a);
    cyc(1'b0, 1'b1, a, '0, 1'b0);
    cyc(1'b0, 1'b1, a, '0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog no finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [DATA_W-1:0] a, d;
    bit w, r, rs;
    checks = 0;
    errors = 0;
    edge_n = 0;
    wait_m = 1'b0;
    mmo_m  = '0;
    for (int k = 0; k < N_OUT; k++) out_m[k] = '0;
    for (int k = 0; k < 64; k++) hist[k] = '0;
    for (int k = 0; k < DEPTH; k++) ram_m[k] = '0;
    in_port   = '0;
    reset     = 1'b1;
    bus.mwmem = 1'b0;
    bus.mrmem = 1'b0;
    bus.malu  = '0;
    bus.mb    = '0;
    @(negedge clock);
    repeat (3) cyc(1'b0, 1'b0, '0, '0, 1'b1);

    // Reset clears an output register written just before
    cyc(1'b1, 1'b0, 32'h0000_0080, 32'h0000_00A5, 1'b0);
    cyc(1'b0, 1'b0, '0, '0, 1'b1);
    cyc(1'b0, 1'b0, '0, '0, 1'b0);

    // Give every RAM word a known value
    for (int k = 0; k < DEPTH; k++) cyc(1'b1, 1'b0, DATA_W'(k * 4), $urandom, 1'b0);

    // Store then load the same word
    cyc(1'b1, 1'b0, 32'h0000_0008, 32'h1234_5678, 1'b0);
    load2(32'h0000_0008);

    // Synchronised input port, then an unmapped io port
    in_port[DATA_W +: DATA_W] = 32'hDEAD_BEEF;
    repeat (3) cyc(1'b0, 1'b0, '0, '0, 1'b0);
    load2(32'h0000_0084);
    load2(32'h0000_00BC);

    // io store leaves the aliased RAM word untouched
    load2(32'h0000_0010);
    cyc(1'b1, 1'b0, 32'h0000_0090, 32'h0000_0055, 1'b0);
    load2(32'h0000_0010);

    // Back-to-back loads
    load2(32'h0000_0000);
    load2(32'h0000_0004);

    // Output readback window (zero unless the readback build is selected)
    cyc(1'b1, 1'b0, 32'h0000_0080, 32'h0000_0077, 1'b0);
    load2(32'h0000_0088);

    // Illegal store+load encoding: store wins, no stall
    cyc(1'b1, 1'b1, 32'h0000_000C, 32'hCAFE_F00D, 1'b0);
    load2(32'h0000_000C);

    // Reset during WAIT
    cyc(1'b0, 1'b1, 32'h0000_0008, '0, 1'b0);
    cyc(1'b0, 1'b1, 32'h0000_0008, '0, 1'b1);
    cyc(1'b0, 1'b0, '0, '0, 1'b0);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) in_port = {$urandom, $urandom};
      rs = ($urandom_range(0, 79) == 0);
      w  = !rs && ($urandom_range(0, 2) == 0);
      r  = !rs && ($urandom_range(0, 1) == 0);
      a  = $urandom;
      a[IO_SEL_BIT] = $urandom_range(0, 1);
      d  = $urandom;
      cyc(w, r, a, d, rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
